// File: rtl/alu_cmd_issuer_if.sv
// Request, ALU-drive and response signals of the ALU command issuer.
// slave = the issuer itself, master = the requester / ALU / response sink side.
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [4:0]       alu_select;
  logic [31:0]      alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [7:0]       illegal_cnt;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_tag,
           rsp_err, busy, illegal_cnt
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_select, rsp_valid, rsp_data, rsp_tag,
           rsp_err, busy, illegal_cnt
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command sequencer for the dual-lane ALU: buffers tagged requests, issues them
// to the ALU on registered operands, and returns results in request order.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_cmd_issuer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  entry_t           fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  state_t           state_reg;
  logic [31:0]      alu_a_reg;
  logic [31:0]      alu_b_reg;
  logic [4:0]       alu_select_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      rsp_data_reg;
  logic [TAG_W-1:0] rsp_tag_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic [7:0]       illegal_cnt_reg;

  logic   fifo_full;
  logic   push;
  logic   pop;
  entry_t head;
  logic   head_legal;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign push       = bus.cmd_valid && !fifo_full;
  // A pop is only taken when the FSM can accept a new entry on this edge.
  assign pop        = (count_reg != '0) &&
                      ((state_reg == IDLE) || ((state_reg == RESP) && bus.rsp_ready));
  assign head       = fifo_mem[rd_ptr_reg];
  // Function codes 7, E and F select unpopulated ALU mux inputs.
  assign head_legal = !((head.op[3:0] == 4'h7) || (head.op[3:0] >= 4'hE));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_select_reg  <= '0;
      tag_reg         <= '0;
      rsp_data_reg    <= '0;
      rsp_tag_reg     <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= 1'b0;
      illegal_cnt_reg <= '0;
    end else begin
      case (state_reg)
        EXEC: begin
          rsp_data_reg  <= bus.alu_out;
          rsp_err_reg   <= 1'b0;
          rsp_tag_reg   <= tag_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready && (count_reg == '0)) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: ;
      endcase

      // Issue of a popped entry overrides the RESP hold above.
      if (pop) begin
        if (head_legal) begin
          alu_a_reg      <= head.a;
          alu_b_reg      <= head.b;
          alu_select_reg <= head.op;
          tag_reg        <= head.tag;
          rsp_valid_reg  <= 1'b0;
          state_reg      <= EXEC;
        end else begin
          rsp_data_reg  <= '0;
          rsp_err_reg   <= 1'b1;
          rsp_tag_reg   <= head.tag;
          rsp_valid_reg <= 1'b1;
          if (illegal_cnt_reg != 8'hFF) begin
            illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
          end
          state_reg <= RESP;
        end
      end
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.alu_a       = alu_a_reg;
  assign bus.alu_b       = alu_b_reg;
  assign bus.alu_select  = alu_select_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.rsp_tag     = rsp_tag_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.busy        = (state_reg != IDLE) || (count_reg != '0);
  assign bus.illegal_cnt = illegal_cnt_reg;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, multi-cycle
// sequences, and randomized traffic against an in-order response model.
module tb_alu_cmd_issuer;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int NV    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_cmd_issuer_if #(.TAG_W(TAG_W)) bus ();

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: bit 4 inverts the result, so the mode bit is observable.
  function automatic logic [31:0] alu_fn(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (sel[3:0])
      4'h0:    r = a + b;
      4'h1:    r = a - b;
      4'h2:    r = a << b[4:0];
      4'h3:    r = a >> b[4:0];
      4'h4:    r = a + 32'd1;
      4'h5:    r = {a[15:0], a[31:16]};
      4'h6:    r = b;
      4'h8:    r = a & b;
      4'h9:    r = a | b;
      4'hA:    r = ~(a & b);
      4'hB:    r = ~(a | b);
      4'hC:    r = ~a;
      4'hD:    r = a ^ b;
      default: r = 32'hDEAD_BEEF;
    endcase
    return sel[4] ? ~r : r;
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return !((op[3:0] == 4'h7) || (op[3:0] == 4'hE) || (op[3:0] == 4'hF));
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_select, bus.alu_a, bus.alu_b);

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   ill_model = 0;

  // Scoreboard: every accepted request produces exactly one response, in order.
  task automatic sb_step();
    rsp_t e;
    rsp_t g;
    if (rst) begin
      exp_q.delete();
      ill_model = 0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        g.data = bus.rsp_data;
        g.tag  = bus.rsp_tag;
        g.err  = bus.rsp_err;
        g.cyc  = cyc;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_rsp: got tag %0d data 0x%08h, required no response", g.tag, g.data);
        end else begin
          e = exp_q.pop_front();
          check("sb_rsp_data", g.data, e.data);
          check("sb_rsp_tag", 32'(g.tag), 32'(e.tag));
          check("sb_rsp_err", 32'(g.err), 32'(e.err));
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        e.err  = !is_legal(bus.cmd_op);
        e.data = e.err ? 32'h0 : alu_fn(bus.cmd_op, bus.cmd_a, bus.cmd_b);
        e.tag  = bus.cmd_tag;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (e.err && (ill_model < 255)) ill_model++;
      end
    end
  endtask

  always @(negedge clk) sb_step();

  // Offer one request from posedge+1 until it is accepted (bounded).
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    logic ok;
    ok            = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    for (int i = 0; (i < 50) && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready got 0 for 50 cycles, required 1");
    end
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    for (int i = 0; (i < max_cycles) && (bus.busy || bus.rsp_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(bus.busy), 32'h0);
  endtask

  typedef struct {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_data;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  vec_t       vecs [NV];
  logic [4:0] ill_ops [6];

  initial begin : main
    logic [4:0] last_sel;
    logic [31:0] last_a;
    int ill_exp;
    int lat;
    int acc;
    int idx;
    int nerr;
    logic took;

    vecs[0] = '{5'h08, 32'hFFFF_0F0F, 32'h00FF_FF00, 4'd3,  32'h00FF_0F00, 1'b0, 2};
    vecs[1] = '{5'h17, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9,  32'h0000_0000, 1'b1, 1};
    vecs[2] = '{5'h00, 32'h0000_0005, 32'h0000_0007, 4'd4,  32'h0000_000C, 1'b0, 2};
    vecs[3] = '{5'h1D, 32'hFFFF_0000, 32'h00FF_0000, 4'd5,  32'h00FF_FFFF, 1'b0, 2};
    vecs[4] = '{5'h0E, 32'h1111_1111, 32'h2222_2222, 4'd6,  32'h0000_0000, 1'b1, 1};
    vecs[5] = '{5'h02, 32'h0000_0001, 32'h0000_0004, 4'd7,  32'h0000_0010, 1'b0, 2};
    vecs[6] = '{5'h0F, 32'h3333_3333, 32'h4444_4444, 4'd8,  32'h0000_0000, 1'b1, 1};
    vecs[7] = '{5'h0C, 32'h0000_FFFF, 32'h0000_0000, 4'd10, 32'hFFFF_0000, 1'b0, 2};
    vecs[8] = '{5'h06, 32'h0000_0001, 32'hCAFE_F00D, 4'd11, 32'hCAFE_F00D, 1'b0, 2};
    vecs[9] = '{5'h07, 32'h5555_5555, 32'h6666_6666, 4'd12, 32'h0000_0000, 1'b1, 1};
    ill_ops = '{5'h07, 5'h0E, 5'h0F, 5'h17, 5'h1E, 5'h1F};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_illegal_cnt", 32'(bus.illegal_cnt), 32'h0);
    check("rst_alu_select", 32'(bus.alu_select), 32'h0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;

    // Directed vectors into an idle block
    last_sel = 5'h00;
    last_a   = 32'h0;
    ill_exp  = 0;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      lat = 0;
      for (int c = 1; (c <= 8) && (lat == 0); c++) begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid) lat = c;
      end
      if (vecs[i].exp_err) begin
        ill_exp++;
      end else begin
        last_sel = vecs[i].op;
        last_a   = vecs[i].a;
      end
      check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
      check("vec_rsp_data", bus.rsp_data, vecs[i].exp_data);
      check("vec_rsp_tag", 32'(bus.rsp_tag), 32'(vecs[i].tag));
      check("vec_rsp_err", 32'(bus.rsp_err), 32'(vecs[i].exp_err));
      check("vec_alu_select", 32'(bus.alu_select), 32'(last_sel));
      check("vec_alu_a", bus.alu_a, last_a);
      check("vec_illegal_cnt", 32'(bus.illegal_cnt), 32'(ill_exp));
      @(posedge clk);
      #1;
      check("vec_rsp_valid_drop", 32'(bus.rsp_valid), 32'h0);
    end

    // Back-to-back legal ops: in order, two cycles apart
    got_q.delete();
    send(5'h0D, 32'hAAAA_5555, 32'hFFFF_FFFF, 4'd1);
    send(5'h09, 32'h1200_0034, 32'h0056_7800, 4'd2);
    wait_idle("b2b_idle", 50);
    check("b2b_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("b2b_data0", got_q[0].data, 32'h5555_AAAA);
      check("b2b_tag0", 32'(got_q[0].tag), 32'd1);
      check("b2b_data1", got_q[1].data, 32'h1256_7834);
      check("b2b_tag1", 32'(got_q[1].tag), 32'd2);
      check("b2b_gap", 32'(got_q[1].cyc - got_q[0].cyc), 32'd2);
    end

    // Backpressure: DEPTH+1 requests accepted, then cmd_ready falls
    bus.rsp_ready = 1'b0;
    got_q.delete();
    acc = 0;
    idx = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 5'h09;
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
    bus.cmd_tag   = TAG_W'(idx);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      took = bus.cmd_ready && bus.cmd_valid;
      @(posedge clk);
      #1;
      if (took) begin
        acc++;
        idx++;
        if (idx < 6) begin
          bus.cmd_a   = $urandom;
          bus.cmd_b   = $urandom;
          bus.cmd_tag = TAG_W'(idx);
        end
      end
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(acc), 32'(DEPTH + 1));
    check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'h0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_idle("bp_idle", 100);
    check("bp_rsp_count", 32'(got_q.size()), 32'(DEPTH + 1));
    for (int i = 0; i < got_q.size(); i++) begin
      check("bp_rsp_tag_order", 32'(got_q[i].tag), 32'(i));
    end
    check("bp_cmd_ready_high", 32'(bus.cmd_ready), 32'h1);

    // Reset while in EXEC with two entries queued
    bus.rsp_ready = 1'b0;
    send(5'h09, 32'h0000_00A0, 32'h0000_000A, 4'hA);
    send(5'h08, 32'hFFFF_FFFF, 32'h0000_0B0B, 4'hB);
    send(5'h0D, 32'h0000_0C00, 32'h0000_00CC, 4'hC);
    send(5'h00, 32'h0000_0D00, 32'h0000_000D, 4'hD);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("exec_busy", 32'(bus.busy), 32'h1);
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("exec_alu_select", 32'(bus.alu_select), 32'h08);
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("arst_rsp_data", bus.rsp_data, 32'h0);
    check("arst_rsp_tag", 32'(bus.rsp_tag), 32'h0);
    check("arst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("arst_alu_a", bus.alu_a, 32'h0);
    check("arst_alu_b", bus.alu_b, 32'h0);
    check("arst_alu_select", 32'(bus.alu_select), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_illegal_cnt", 32'(bus.illegal_cnt), 32'h0);
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    got_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("arst_no_rsp", 32'(got_q.size()), 32'h0);
    send(5'h09, 32'hF000_0000, 32'h0000_000F, 4'h6);
    wait_idle("arst_new_idle", 20);
    check("arst_new_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) begin
      check("arst_new_data", got_q[0].data, 32'hF000_000F);
    end

    // 260 illegal requests: counter saturates, every response is an error
    got_q.delete();
    for (int i = 0; i < 260; i++) begin
      send(ill_ops[$urandom_range(0, 5)], $urandom, $urandom, TAG_W'(i));
    end
    wait_idle("sat_idle", 100);
    check("sat_illegal_cnt", 32'(bus.illegal_cnt), 32'd255);
    check("sat_rsp_count", 32'(got_q.size()), 32'd260);
    nerr = 0;
    foreach (got_q[i]) nerr += int'(got_q[i].err);
    check("sat_all_err", 32'(nerr), 32'd260);

    // Randomized traffic against the scoreboard
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_op    = 5'($urandom_range(0, 31));
      bus.cmd_a     = $urandom;
      bus.cmd_b     = $urandom;
      bus.cmd_tag   = TAG_W'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle("rand_idle", 100);
    check("rand_pending", 32'(exp_q.size()), 32'h0);
    check("rand_illegal_cnt", 32'(bus.illegal_cnt), 32'(ill_model));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
